// File: rtl/simon_sequence.sv
// Simon pattern store: appends one LFSR symbol per round and replays
// the stored sequence as timed show pulses for the LED driver.
module simon_sequence #(
    parameter int MAX_LEN    = 16,
    parameter int ON_CYCLES  = 25_000_000,
    parameter int OFF_CYCLES = 12_500_000
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [1:0]                 rnd,
    input  logic                       start,
    input  logic                       next_round,
    output logic                       show_valid,
    output logic [1:0]                 show_sym,
    output logic                       busy,
    output logic                       done,
    output logic [$clog2(MAX_LEN):0]   len,
    output logic                       full,
    input  logic [$clog2(MAX_LEN)-1:0] rd_idx,
    output logic [1:0]                 rd_sym
);

    localparam int IW   = $clog2(MAX_LEN);
    localparam int LW   = IW + 1;
    localparam int TMAX = (ON_CYCLES > OFF_CYCLES) ? ON_CYCLES : OFF_CYCLES;
    localparam int TW   = (TMAX > 1) ? $clog2(TMAX) : 1;

    localparam logic [TW-1:0] ON_LD  = TW'(ON_CYCLES - 1);
    localparam logic [TW-1:0] OFF_LD = TW'(OFF_CYCLES - 1);
    localparam logic [LW-1:0] LEN_MAX = LW'(MAX_LEN);

    typedef enum logic [2:0] {
        S_IDLE,
        S_APPEND,
        S_PLAY_ON,
        S_PLAY_OFF,
        S_DONE
    } state_t;

    state_t        state, state_n;
    logic [LW-1:0] len_n;
    logic [IW-1:0] idx, idx_n;
    logic [TW-1:0] tmr, tmr_n;
    logic          we;
    logic          last;
    logic [1:0]    sym_n;

    logic [1:0] mem [MAX_LEN];

    assign last   = (LW'(idx) == len - LW'(1));
    assign rd_sym = mem[rd_idx];

    // The first symbol of a fresh sequence is written on the same edge
    // that starts its display, so bypass the memory for it.
    always_comb begin
        sym_n = mem[idx_n];
        if (we && len == '0) begin
            sym_n = rnd;
        end
    end

    always_comb begin
        state_n = state;
        len_n   = len;
        idx_n   = idx;
        tmr_n   = tmr;
        we      = 1'b0;
        unique case (state)
            S_IDLE: begin
                if (start) begin
                    len_n   = '0;
                    state_n = S_APPEND;
                end else if (next_round) begin
                    if (full) begin
                        idx_n   = '0;
                        tmr_n   = ON_LD;
                        state_n = S_PLAY_ON;
                    end else begin
                        state_n = S_APPEND;
                    end
                end
            end
            S_APPEND: begin
                we      = 1'b1;
                len_n   = len + 1'b1;
                idx_n   = '0;
                tmr_n   = ON_LD;
                state_n = S_PLAY_ON;
            end
            S_PLAY_ON: begin
                if (tmr == '0) begin
                    tmr_n   = OFF_LD;
                    state_n = S_PLAY_OFF;
                end else begin
                    tmr_n = tmr - 1'b1;
                end
            end
            S_PLAY_OFF: begin
                if (tmr != '0) begin
                    tmr_n = tmr - 1'b1;
                end else if (last) begin
                    state_n = S_DONE;
                end else begin
                    idx_n   = idx + 1'b1;
                    tmr_n   = ON_LD;
                    state_n = S_PLAY_ON;
                end
            end
            S_DONE: begin
                state_n = S_IDLE;
            end
            default: begin
                state_n = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= S_IDLE;
            len        <= '0;
            idx        <= '0;
            tmr        <= '0;
            show_valid <= 1'b0;
            show_sym   <= 2'b00;
            busy       <= 1'b0;
            done       <= 1'b0;
            full       <= 1'b0;
        end else begin
            state      <= state_n;
            len        <= len_n;
            idx        <= idx_n;
            tmr        <= tmr_n;
            show_valid <= (state_n == S_PLAY_ON);
            show_sym   <= (state_n == S_PLAY_ON) ? sym_n : 2'b00;
            busy       <= (state_n != S_IDLE);
            done       <= (state_n == S_DONE);
            full       <= (len_n == LEN_MAX);
        end
    end

    always_ff @(posedge clk) begin
        if (we && !rst) begin
            mem[len[IW-1:0]] <= rnd;
        end
    end

endmodule

// File: tb/tb_simon_sequence.sv
// Directed round sequence with randomized symbols, checked against a
// queue-based model of the show/done timing.
module tb_simon_sequence;

    localparam int ML  = 4;
    localparam int ON  = 3;
    localparam int OFF = 2;
    localparam int P   = ON + OFF;

    logic       clk = 1'b0;
    logic       rst;
    logic [1:0] rnd;
    logic       start;
    logic       next_round;
    logic       show_valid;
    logic [1:0] show_sym;
    logic       busy;
    logic       done;
    logic [2:0] len;
    logic       full;
    logic [1:0] rd_idx;
    logic [1:0] rd_sym;

    int passed = 0;
    int failed = 0;
    int total  = 0;

    logic [1:0] model[$];

    always #5 clk = ~clk;

    simon_sequence #(
        .MAX_LEN   (ML),
        .ON_CYCLES (ON),
        .OFF_CYCLES(OFF)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .rnd       (rnd),
        .start     (start),
        .next_round(next_round),
        .show_valid(show_valid),
        .show_sym  (show_sym),
        .busy      (busy),
        .done      (done),
        .len       (len),
        .full      (full),
        .rd_idx    (rd_idx),
        .rd_sym    (rd_sym)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else begin
            failed++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic chk_store();
        chk("len", 32'(len), 32'(model.size()));
        chk("full", 32'(full), 32'(model.size() == ML));
        for (int i = 0; i < model.size(); i++) begin
            rd_idx = 2'(i);
            #1;
            chk($sformatf("rd_sym[%0d]", i), 32'(rd_sym), 32'(model[i]));
        end
    endtask

    // Issue one command; inj pulses both commands in cycle inj,
    // rst_at asserts reset in cycle rst_at (cycles counted after the command edge).
    task automatic run(input bit st, input bit nr, input logic [1:0] sym,
                       input int inj, input int rst_at);
        int off;
        int n;
        int last_c;
        int p;
        logic exp_sv;
        logic [1:0] exp_sym;
        if (st) model.delete();
        if (st || model.size() < ML) begin
            model.push_back(sym);
            off = 2;
        end else begin
            off = 1;
        end
        n      = model.size();
        last_c = off + n * P;
        start      = st;
        next_round = nr;
        rnd        = 2'($urandom);
        tick();
        start      = 1'b0;
        next_round = 1'b0;
        for (int c = 1; c <= last_c + 1; c++) begin
            rnd = (c == 1) ? sym : 2'($urandom);
            p = c - off;
            exp_sv  = (p >= 0) && (p < n * P) && ((p % P) < ON);
            exp_sym = exp_sv ? model[p / P] : 2'b00;
            chk($sformatf("show_valid c%0d", c), 32'(show_valid), 32'(exp_sv));
            chk($sformatf("show_sym c%0d", c), 32'(show_sym), 32'(exp_sym));
            chk($sformatf("busy c%0d", c), 32'(busy), 32'(c <= last_c));
            chk($sformatf("done c%0d", c), 32'(done), 32'(c == last_c));
            if (c == rst_at) begin
                rst = 1'b1;
                tick();
                rst = 1'b0;
                model.delete();
                for (int j = 0; j < 6; j++) begin
                    chk("rst busy", 32'(busy), 32'(0));
                    chk("rst show_valid", 32'(show_valid), 32'(0));
                    chk("rst show_sym", 32'(show_sym), 32'(0));
                    chk("rst done", 32'(done), 32'(0));
                    chk("rst len", 32'(len), 32'(0));
                    tick();
                end
                return;
            end
            if (c == inj) begin
                start      = 1'b1;
                next_round = 1'b1;
                tick();
                start      = 1'b0;
                next_round = 1'b0;
            end else begin
                tick();
            end
        end
        chk_store();
    endtask

    initial begin
        rst        = 1'b1;
        rnd        = 2'b00;
        start      = 1'b0;
        next_round = 1'b0;
        rd_idx     = 2'b00;
        tick();
        tick();
        rst = 1'b0;
        chk("reset show_valid", 32'(show_valid), 32'(0));
        chk("reset show_sym", 32'(show_sym), 32'(0));
        chk("reset busy", 32'(busy), 32'(0));
        chk("reset done", 32'(done), 32'(0));
        chk("reset len", 32'(len), 32'(0));
        chk("reset full", 32'(full), 32'(0));
        tick();

        run(1'b1, 1'b0, 2'd2, 0, 0);
        run(1'b0, 1'b1, 2'd1, 0, 0);
        run(1'b0, 1'b1, 2'd3, 0, 0);
        run(1'b0, 1'b1, 2'd0, 0, 0);
        run(1'b0, 1'b1, 2'($urandom), 0, 0);
        run(1'b0, 1'b1, 2'($urandom), 3, 0);

        run(1'b1, 1'b0, 2'($urandom), 0, 0);
        run(1'b0, 1'b1, 2'($urandom), 0, 0);
        run(1'b0, 1'b1, 2'($urandom), 4, 0);
        run(1'b1, 1'b1, 2'($urandom), 0, 0);

        run(1'b0, 1'b1, 2'($urandom), 0, 0);
        run(1'b0, 1'b1, 2'($urandom), 0, 10);

        run(1'b1, 1'b0, 2'($urandom), 0, 0);
        for (int r = 0; r < 4; r++) begin
            run(1'b0, 1'b1, 2'($urandom), 0, 0);
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/simon_sequence.md
# simon_sequence

Pattern store and playback stage downstream of the 2-bit LFSR in the game FSM. On each new round it samples the LFSR's `rnd` output, appends that symbol to an internal sequence memory, then replays the whole sequence as timed show pulses for the light/LED driver. A combinational read port lets the player-input checker compare presses against stored symbols.

## Interface
Parameters:
- `MAX_LEN`, 16: maximum sequence length in symbols; a power of two, at least 2.
- `ON_CYCLES`, 25_000_000: cycles each symbol is shown; at least 1.
- `OFF_CYCLES`, 12_500_000: blank cycles after each symbol; at least 1.

Ports (one clock; reset is synchronous and active-high):
- `clk` in 1: system clock.
- `rst` in 1: synchronous, active-high reset.
- `rnd` in 2: symbol from the LFSR, sampled only in APPEND.
- `start` in 1: one-cycle pulse. Clears the sequence, then appends one symbol and plays it.
- `next_round` in 1: one-cycle pulse. Appends one symbol and plays the whole sequence.
- `show_valid` out 1: high while a symbol is being displayed.
- `show_sym` out 2: symbol being displayed. Reads 0 when `show_valid` is low.
- `busy` out 1: high from APPEND through DONE inclusive.
- `done` out 1: one-cycle pulse when playback completes.
- `len` out $clog2(MAX_LEN)+1: number of stored symbols.
- `full` out 1: asserted when `len == MAX_LEN`.
- `rd_idx` in $clog2(MAX_LEN): checker read index.
- `rd_sym` out 2: `mem[rd_idx]`, combinational read. Undefined content for `rd_idx >= len`.

## Operation
State machine states: IDLE, APPEND, PLAY_ON, PLAY_OFF, DONE.
- Reset values: state IDLE; `len` 0; play index 0; timer 0; `show_valid` 0; `show_sym` 0; `busy` 0; `done` 0; `full` 0. Memory contents are not reset.
- IDLE:
  - `start` has priority over `next_round` when both are asserted.
  - `start`: `len <= 0`, then go to APPEND.
  - `next_round` with `full == 0`: go to APPEND.
  - `next_round` with `full == 1`: no append. Go directly to PLAY_ON with index 0 and replay the existing sequence.
  - `next_round` with `len == 0` behaves as a normal append.
- APPEND (one cycle): `mem[len] <= rnd`, `len <= len + 1`, index reset to 0, timer loaded to `ON_CYCLES - 1`, go to PLAY_ON.
- PLAY_ON:
  - `show_valid = 1` and `show_sym = mem[index]` (registered outputs).
  - Timer decrements each cycle. At 0: load `OFF_CYCLES - 1` and go to PLAY_OFF.
- PLAY_OFF:
  - Outputs blank.
  - At timer 0, if `index == len - 1`: go to DONE.
  - Otherwise: `index + 1`, reload `ON_CYCLES - 1`, go to PLAY_ON.
- DONE (one cycle): `done = 1`, then go to IDLE.
- `start` and `next_round` are ignored in every state except IDLE; no queuing.
- `rst` asserted mid-playback returns all outputs to reset values on the next edge and discards the sequence (`len` 0).
- Index and timer widths must hold `MAX_LEN - 1` and `max(ON_CYCLES, OFF_CYCLES) - 1` without wrap.

## Timing
- A command is sampled at edge k. APPEND occupies cycle k+1 and `rnd` is captured at edge k+1.
- First `show_valid` rises in cycle k+2. Each symbol is high for exactly `ON_CYCLES` cycles, then low for `OFF_CYCLES` cycles.
- `done` is high in cycle k+2+len·(ON_CYCLES+OFF_CYCLES). `busy` is high during cycles k+1 through that DONE cycle.
- Full-replay path (no APPEND): everything is one cycle earlier; first `show_valid` is in cycle k+1.
- The next command is accepted at the edge that ends the cycle following DONE (state IDLE).
- The written symbol is readable on `rd_sym` from cycle k+2.

## Test plan
Bench uses `ON=3`, `OFF=2`, `MAX_LEN=4`.
- Reset, then pulse `start` with `rnd=2'b10`. Required: `len=1`; `show_valid` high for 3 cycles with `show_sym=2`, starting 2 cycles after the pulse; `done` 7 cycles after the pulse; `rd_sym[0]=2`.
- Three `next_round` pulses, each after `done`, with `rnd` = 1, 3, 0. Required:
  - `len` goes 2, 3, 4 and `full=1` after the last.
  - The final playback shows 2, 1, 3, 0 with 3-on/2-off spacing.
  - `done` 22 cycles after the last pulse.
- `next_round` while `full`. Required: `len` stays 4, `rnd` is ignored, same 4-symbol replay, `done` 21 cycles after the pulse.
- `start` and `next_round` pulsed during PLAY_ON. Required: no effect on `len`, the shown sequence, or the timing of `done`.
- `start` and `next_round` together in IDLE with `len=3`. Required: `len` becomes 1 (`start` wins).
- `rst` asserted in PLAY_OFF of the second symbol. Required: next cycle `busy=0`, `show_valid=0`, `len=0`, `done` never pulses; a subsequent `start` works normally.
